// File: rtl/rx_drop_stat_pkg.sv
// Shared types and helpers for the RX drop-statistics collector.
// The popcount helper is sized for the largest supported region count.
package rx_drop_stat_pkg;

    localparam int MAX_REGIONS = 32;
    localparam int INC_W       = $clog2(MAX_REGIONS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_t;

    // Callers zero-extend narrower vectors and cast the result down to their own width.
    function automatic logic [INC_W-1:0] popcount(input logic [MAX_REGIONS-1:0] vec);
        logic [INC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_REGIONS; i++) begin
            cnt = cnt + INC_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rx_drop_stat_popcnt.sv
// Registered stage 1: counts the frames and the dropped frames carried by
// one event word.
module rx_drop_stat_popcnt
    import rx_drop_stat_pkg::*;
#(
    parameter int REGIONS = 4,
    parameter int IW      = $clog2(REGIONS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ev_vld,
    input  logic [REGIONS-1:0] ev_eof,
    input  logic [REGIONS-1:0] ev_drop,
    output logic [IW-1:0]      f_inc,
    output logic [IW-1:0]      d_inc
);

    // A drop bit only counts where it accompanies an end-of-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_inc <= '0;
            d_inc <= '0;
        end else if (ev_vld) begin
            f_inc <= IW'(popcount(MAX_REGIONS'(ev_eof)));
            d_inc <= IW'(popcount(MAX_REGIONS'(ev_eof & ev_drop)));
        end else begin
            f_inc <= '0;
            d_inc <= '0;
        end
    end

endmodule

// File: rtl/rx_drop_stat_collector.sv
// Accumulates received/dropped frame counts from the RX MAC lite drop probe
// and hands out atomic snapshots through a valid/ack handshake.
module rx_drop_stat_collector
    import rx_drop_stat_pkg::*;
#(
    parameter int REGIONS     = 4,
    parameter int CNT_W       = 48,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               EV_VLD,
    input  logic [REGIONS-1:0] EV_EOF,
    input  logic [REGIONS-1:0] EV_DROP,
    input  logic               CLR,
    input  logic               RD_REQ,
    output logic               RD_BUSY,
    output logic               RD_VLD,
    input  logic               RD_ACK,
    output logic [CNT_W-1:0]   RD_FRAMES,
    output logic [CNT_W-1:0]   RD_DROPS,
    output logic [1:0]         RD_OVF
);

    localparam int IW = $clog2(REGIONS + 1);

    logic [IW-1:0]    f_inc;
    logic [IW-1:0]    d_inc;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] drops;
    logic [1:0]       ovf;
    logic [CNT_W:0]   frames_sum;
    logic [CNT_W:0]   drops_sum;
    logic             rd_take;
    rd_state_t        state;
    rd_state_t        state_nxt;

    rx_drop_stat_popcnt #(
        .REGIONS (REGIONS),
        .IW      (IW)
    ) u_popcnt (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .ev_vld  (EV_VLD),
        .ev_eof  (EV_EOF),
        .ev_drop (EV_DROP),
        .f_inc   (f_inc),
        .d_inc   (d_inc)
    );

    always_comb begin
        frames_sum = {1'b0, frames} + (CNT_W + 1)'(f_inc);
        drops_sum  = {1'b0, drops} + (CNT_W + 1)'(d_inc);
    end

    assign rd_take = (state == IDLE) && RD_REQ;

    // On clear-on-read the counters restart from this edge's increment so nothing is lost.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frames <= '0;
            drops  <= '0;
            ovf    <= '0;
        end else if (CLR) begin
            frames <= '0;
            drops  <= '0;
            ovf    <= '0;
        end else if (rd_take && CLR_ON_READ) begin
            frames <= CNT_W'(f_inc);
            drops  <= CNT_W'(d_inc);
            ovf    <= '0;
        end else begin
            frames <= frames_sum[CNT_W-1:0];
            drops  <= drops_sum[CNT_W-1:0];
            ovf    <= ovf | {drops_sum[CNT_W], frames_sum[CNT_W]};
        end
    end

    // Snapshot takes the pre-edge values and is frozen for the whole HOLD.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_FRAMES <= '0;
            RD_DROPS  <= '0;
            RD_OVF    <= '0;
        end else if (rd_take) begin
            RD_FRAMES <= frames;
            RD_DROPS  <= drops;
            RD_OVF    <= ovf;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (RD_REQ) state_nxt = HOLD;
            HOLD:    if (RD_ACK) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        RD_VLD  = (state == HOLD);
        RD_BUSY = (state == HOLD);
    end

endmodule

// File: tb/tb_rx_drop_stat_collector.sv
// Randomized and directed checks of two collector instances (plain, and
// 16-bit clear-on-read) against a count-based reference model.
module tb_rx_drop_stat_collector;

    localparam int REGIONS = 4;
    localparam int W_A     = 8;
    localparam int W_B     = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ev_vld;
    logic [3:0]     ev_eof;
    logic [3:0]     ev_drop;
    logic           clr;
    logic           rd_req;
    logic           rd_ack;
    logic           busy_a, vld_a, busy_b, vld_b;
    logic [W_A-1:0] frames_a, drops_a;
    logic [W_B-1:0] frames_b, drops_b;
    logic [1:0]     ovf_a, ovf_b;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: plain integer counts per instance plus the shared read handshake.
    int       cnt_w[2] = '{W_A, W_B};
    bit       cor[2]   = '{1'b0, 1'b1};
    longint   m_f[2], m_d[2], s_f[2], s_d[2];
    logic [1:0] m_ovf[2], s_ovf[2];
    bit       m_hold;
    int       pend_f, pend_d;
    longint   snap_sum, eof_total;

    rx_drop_stat_collector #(.REGIONS(REGIONS), .CNT_W(W_A), .CLR_ON_READ(1'b0)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .EV_VLD(ev_vld), .EV_EOF(ev_eof), .EV_DROP(ev_drop),
        .CLR(clr), .RD_REQ(rd_req), .RD_BUSY(busy_a), .RD_VLD(vld_a), .RD_ACK(rd_ack),
        .RD_FRAMES(frames_a), .RD_DROPS(drops_a), .RD_OVF(ovf_a)
    );

    rx_drop_stat_collector #(.REGIONS(REGIONS), .CNT_W(W_B), .CLR_ON_READ(1'b1)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .EV_VLD(ev_vld), .EV_EOF(ev_eof), .EV_DROP(ev_drop),
        .CLR(clr), .RD_REQ(rd_req), .RD_BUSY(busy_b), .RD_VLD(vld_b), .RD_ACK(rd_ack),
        .RD_FRAMES(frames_b), .RD_DROPS(drops_b), .RD_OVF(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_f[i] = 0; m_d[i] = 0; s_f[i] = 0; s_d[i] = 0;
            m_ovf[i] = 2'b00; s_ovf[i] = 2'b00;
        end
        m_hold = 1'b0;
        pend_f = 0;
        pend_d = 0;
    endtask

    task automatic modelUpdate();
        bit     take;
        longint lim;
        take = !m_hold && rd_req;
        for (int i = 0; i < 2; i++) begin
            lim = longint'(1) << cnt_w[i];
            if (take) begin
                s_f[i] = m_f[i]; s_d[i] = m_d[i]; s_ovf[i] = m_ovf[i];
            end
            if (clr) begin
                m_f[i] = 0; m_d[i] = 0; m_ovf[i] = 2'b00;
            end else if (take && cor[i]) begin
                m_f[i] = pend_f; m_d[i] = pend_d; m_ovf[i] = 2'b00;
            end else begin
                m_f[i] += pend_f;
                m_d[i] += pend_d;
                if (m_f[i] >= lim) begin m_f[i] -= lim; m_ovf[i][0] = 1'b1; end
                if (m_d[i] >= lim) begin m_d[i] -= lim; m_ovf[i][1] = 1'b1; end
            end
        end
        if (take) m_hold = 1'b1;
        else if (m_hold && rd_ack) m_hold = 1'b0;
        pend_f = ev_vld ? $countones(ev_eof) : 0;
        pend_d = ev_vld ? $countones(ev_eof & ev_drop) : 0;
    endtask

    task automatic checkAll();
        checkOutput("vld_a", vld_a, m_hold);
        checkOutput("busy_a", busy_a, m_hold);
        checkOutput("vld_b", vld_b, m_hold);
        checkOutput("busy_b", busy_b, m_hold);
        if (m_hold) begin
            checkOutput("frames_a", frames_a, s_f[0]);
            checkOutput("drops_a", drops_a, s_d[0]);
            checkOutput("ovf_a", ovf_a, s_ovf[0]);
            checkOutput("frames_b", frames_b, s_f[1]);
            checkOutput("drops_b", drops_b, s_d[1]);
            checkOutput("ovf_b", ovf_b, s_ovf[1]);
        end
    endtask

    // Called just after a falling edge; drives one cycle and checks at the next falling edge.
    task automatic applyStimulus(input logic vld, input logic [3:0] eof, input logic [3:0] drop,
                                 input logic c, input logic req, input logic ack);
        ev_vld = vld; ev_eof = eof; ev_drop = drop;
        clr = c; rd_req = req; rd_ack = ack;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        ev_vld = 1'b0; ev_eof = '0; ev_drop = '0; clr = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_vld_a", vld_a, 0);
        checkOutput("rst_busy_a", busy_a, 0);
        checkOutput("rst_frames_a", frames_a, 0);
        checkOutput("rst_drops_a", drops_a, 0);
        checkOutput("rst_ovf_a", ovf_a, 0);
        checkOutput("rst_vld_b", vld_b, 0);
        checkOutput("rst_frames_b", frames_b, 0);
        rst_n = 1'b1;

        $display("[TB] basic accumulation");
        repeat (10) applyStimulus(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
        idle(2);
        checkOutput("p1_vld_before", vld_a, 0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("p1_vld_rise", vld_a, 1);
        checkOutput("p1_frames_a", frames_a, 40);
        checkOutput("p1_drops_a", drops_a, 20);
        checkOutput("p1_ovf_a", ovf_a, 0);
        checkOutput("p1_frames_b", frames_b, 40);
        idle(3);
        checkOutput("p1_vld_held", vld_a, 1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("p1_vld_after_ack", vld_a, 0);

        $display("[TB] ignored events");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("p2_frames_a", frames_a, 0);
        checkOutput("p2_drops_a", drops_a, 0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] counter wrap");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (65) applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("p3_frames_a", frames_a, 4);
        checkOutput("p3_ovf_a", ovf_a, 2'b01);
        checkOutput("p3_frames_b", frames_b, 260);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("p3_ovf_a_cleared", ovf_a, 0);
        checkOutput("p3_frames_a_cleared", frames_a, 0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] clear-on-read conservation");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        snap_sum = 0;
        eof_total = 0;
        for (int k = 0; k < 96; k++) begin
            logic [3:0] eof;
            eof = 4'b0001 << $urandom_range(0, 3);
            applyStimulus(1'b1, eof, 4'($urandom), 1'b0, (k % 16) == 15, m_hold && ((k % 16) == 2));
            eof_total += 1;
            if ((k % 16) == 15) snap_sum += frames_b;
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle(1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        snap_sum += frames_b;
        checkOutput("p4_cor_sum", snap_sum, eof_total);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] read and clear on the same edge");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("p5_frames_a", frames_a, 5);
        checkOutput("p5_frames_b", frames_b, 5);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle(1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("p5_next_frames_a", frames_a, 2);
        checkOutput("p5_next_frames_b", frames_b, 2);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 49) == 0,
                          $urandom_range(0, 3) == 0, m_hold && ($urandom_range(0, 2) == 0));
        end
        if (m_hold) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] requests during hold");
        applyStimulus(1'b1, 4'b1011, 4'b0010, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), k == 7, 1'b1, 1'b0);
        end
        checkOutput("p6_vld_held", vld_a, 1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("p6_vld_after_ack", vld_a, 0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("p6_vld_hold2", vld_a, 1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("p6_rst_vld_a", vld_a, 0);
        checkOutput("p6_rst_busy_a", busy_a, 0);
        checkOutput("p6_rst_vld_b", vld_b, 0);
        checkOutput("p6_rst_frames_a", frames_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
